fpu_norm_seq: RTL

FPU_NORM_SEQ -- requirements
Module: fpu_norm_seq

---
 rtl/fpu_norm_seq_pkg.sv | 18 +
 rtl/fpu_norm_seq_ffo.sv | 23 ++
 rtl/fpu_norm_seq.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/fpu_norm_seq_pkg.sv
// Shared types and constants for the sequential mantissa normalizer.
// FSM state encoding plus segment and leading-zero-count widths.
package fpu_norm_pkg;

   localparam int MANT_W_C = 64;
   localparam int SEG_W    = 32;
   localparam int LZC_W    = 7;
   localparam int POS_W    = 5;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SCAN_HI,
      S_SCAN_LO,
      S_SHIFT,
      S_DONE
   } state_e;

endpackage

// File: rtl/fpu_norm_seq_ffo.sv
// Find-first-one from the MSB side: reports the leading-zero count
// of the input word and flags a word with no ones at all.
module fpu_norm_seq_ffo #(
   parameter int LEN = 32
) (
   input  logic [LEN-1:0]         in_i,
   output logic [$clog2(LEN)-1:0] first_one_o,
   output logic                   no_ones_o
);

   // Scan LSB to MSB so the highest set bit is the last one written
   always_comb begin
      first_one_o = '0;
      no_ones_o   = 1'b1;
      for (int i = 0; i < LEN; i++) begin
         if (in_i[i]) begin
            first_one_o = ($clog2(LEN))'(LEN - 1 - i);
            no_ones_o   = 1'b0;
         end
      end
   end

endmodule

// File: rtl/fpu_norm_seq.sv
// Sequential mantissa normalizer: one 32-bit find-first-one shared
// over the high then low half, then an exponent-clamped left shift.
module fpu_norm_seq
   import fpu_norm_pkg::*;
#(
   parameter int MANT_W = 64,
   parameter int EXP_W  = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [MANT_W-1:0] mant_i,
   input  logic [EXP_W-1:0]  exp_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [MANT_W-1:0] mant_o,
   output logic [EXP_W-1:0]  exp_o,
   output logic [LZC_W-1:0]  lzc_o,
   output logic              zero_o,
   output logic              uf_o
);

   state_e             r_state;
   logic [MANT_W-1:0]  r_mant;
   logic [EXP_W-1:0]   r_exp;
   logic [LZC_W-1:0]   r_lzc;
   logic               r_in_ready;
   logic               r_out_valid;
   logic [MANT_W-1:0]  r_mant_o;
   logic [EXP_W-1:0]   r_exp_o;
   logic [LZC_W-1:0]   r_lzc_o;
   logic               r_zero_o;
   logic               r_uf_o;

   logic [SEG_W-1:0]   w_seg;
   logic [POS_W-1:0]   w_pos;
   logic               w_none;
   logic [EXP_W-1:0]   w_lzc_e;
   logic               w_uf;
   logic [EXP_W-1:0]   w_amt;
   logic [MANT_W-1:0]  w_shift;

   // Detector sees the low half only while scanning it
   assign w_seg = (r_state == S_SCAN_LO) ? r_mant[SEG_W-1:0]
                                         : r_mant[MANT_W-1:SEG_W];

   fpu_norm_seq_ffo #(
      .LEN (SEG_W)
   ) u_ffo (
      .in_i        (w_seg),
      .first_one_o (w_pos),
      .no_ones_o   (w_none)
   );

   // Shift is clamped so the exponent bottoms out at zero
   assign w_lzc_e = EXP_W'(r_lzc);
   assign w_uf    = (w_lzc_e > r_exp);
   assign w_amt   = w_uf ? r_exp : w_lzc_e;
   assign w_shift = r_mant << w_amt;

   // Control FSM with all datapath and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_mant      <= '0;
         r_exp       <= '0;
         r_lzc       <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_mant_o    <= '0;
         r_exp_o     <= '0;
         r_lzc_o     <= '0;
         r_zero_o    <= 1'b0;
         r_uf_o      <= 1'b0;
      end else if (flush_i) begin
         r_state     <= S_IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (in_valid_i && r_in_ready) begin
                  r_mant     <= mant_i;
                  r_exp      <= exp_i;
                  r_lzc      <= '0;
                  r_mant_o   <= '0;
                  r_exp_o    <= '0;
                  r_lzc_o    <= '0;
                  r_zero_o   <= 1'b0;
                  r_uf_o     <= 1'b0;
                  r_in_ready <= 1'b0;
                  r_state    <= S_SCAN_HI;
               end
            end
            S_SCAN_HI: begin
               if (!w_none) begin
                  r_lzc   <= LZC_W'(w_pos);
                  r_state <= S_SHIFT;
               end else begin
                  r_state <= S_SCAN_LO;
               end
            end
            S_SCAN_LO: begin
               if (!w_none) begin
                  r_lzc   <= LZC_W'(SEG_W) + LZC_W'(w_pos);
                  r_state <= S_SHIFT;
               end else begin
                  r_lzc       <= LZC_W'(MANT_W);
                  r_lzc_o     <= LZC_W'(MANT_W);
                  r_zero_o    <= 1'b1;
                  r_mant_o    <= '0;
                  r_exp_o     <= '0;
                  r_uf_o      <= 1'b0;
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end
            end
            S_SHIFT: begin
               r_mant_o    <= w_shift;
               r_exp_o     <= r_exp - w_amt;
               r_lzc_o     <= r_lzc;
               r_uf_o      <= w_uf;
               r_zero_o    <= 1'b0;
               r_out_valid <= 1'b1;
               r_state     <= S_DONE;
            end
            S_DONE: begin
               if (out_ready_i) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready_o  = r_in_ready;
   assign out_valid_o = r_out_valid;
   assign mant_o      = r_mant_o;
   assign exp_o       = r_exp_o;
   assign lzc_o       = r_lzc_o;
   assign zero_o      = r_zero_o;
   assign uf_o        = r_uf_o;

endmodule
